// File: rtl/in_switch.sv
// in_switch: fans one AXI-Stream out to two ports, alternating fixed-length
// segments between them, with an independent forward register per output.
module in_switch #(
    parameter int DWIDTH = 128,
    parameter int LWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [LWIDTH-1:0] cfg_seg_len,
    input  logic [LWIDTH-1:0] cfg_seg_num,
    input  logic              cfg_first,
    output logic              busy,
    output logic              done,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DWIDTH-1:0] m_axis_tdata_0,
    output logic              m_axis_tvalid_0,
    input  logic              m_axis_tready_0,
    output logic [DWIDTH-1:0] m_axis_tdata_1,
    output logic              m_axis_tvalid_1,
    input  logic              m_axis_tready_1
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [LWIDTH-1:0] ONE = {{(LWIDTH-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              dest_q, dest_d;
    logic [LWIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [LWIDTH-1:0] seg_cnt_q, seg_cnt_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [LWIDTH-1:0] num_q, num_d;
    logic              done_q, done_d;
    logic              vld0_q, vld0_d, vld1_q, vld1_d;
    logic [DWIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              accept, load0, load1;

    // Only the current destination's register gates the input; the other port drains freely.
    assign s_axis_tready = (state_q == RUN) &&
                           (dest_q ? (~vld1_q | m_axis_tready_1)
                                   : (~vld0_q | m_axis_tready_0));
    assign accept = s_axis_tvalid & s_axis_tready;
    assign load0  = accept & ~dest_q;
    assign load1  = accept & dest_q;

    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign m_axis_tvalid_0 = vld0_q;
    assign m_axis_tvalid_1 = vld1_q;
    assign m_axis_tdata_0  = data0_q;
    assign m_axis_tdata_1  = data1_q;

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        beat_cnt_d = beat_cnt_q;
        seg_cnt_d  = seg_cnt_q;
        len_d      = len_q;
        num_d      = num_q;
        done_d     = 1'b0;

        vld0_d  = load0 | (vld0_q & ~m_axis_tready_0);
        vld1_d  = load1 | (vld1_q & ~m_axis_tready_1);
        data0_d = load0 ? s_axis_tdata : data0_q;
        data1_d = load1 ? s_axis_tdata : data1_q;

        case (state_q)
            IDLE: begin
                if (cfg_start && (cfg_seg_len != '0) && (cfg_seg_num != '0)) begin
                    len_d      = cfg_seg_len;
                    num_d      = cfg_seg_num;
                    dest_d     = cfg_first;
                    beat_cnt_d = '0;
                    seg_cnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (beat_cnt_q == len_q - ONE) begin
                        beat_cnt_d = '0;
                        dest_d     = ~dest_q;
                        seg_cnt_d  = seg_cnt_q + ONE;
                        if (seg_cnt_q == num_q - ONE) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + ONE;
                    end
                end
            end
            DRAIN: begin
                // Look at next-cycle valids so done follows the final handshake by one cycle.
                if (~vld0_d & ~vld1_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dest_q     <= 1'b0;
            beat_cnt_q <= '0;
            seg_cnt_q  <= '0;
            len_q      <= '0;
            num_q      <= '0;
            done_q     <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            beat_cnt_q <= beat_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            len_q      <= len_d;
            num_q      <= num_d;
            done_q     <= done_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
        end
    end

endmodule

// File: tb/tb_in_switch.sv
// Directed bench for in_switch: routing, stalls, backpressure, ignored starts,
// reset mid-transfer and back-to-back transfers.
module tb_in_switch;

    localparam int DW = 128;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [LW-1:0] cfg_seg_len, cfg_seg_num;
    logic          cfg_first;
    logic          busy, done;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_tdata_0, m_axis_tdata_1;
    logic          m_axis_tvalid_0, m_axis_tvalid_1;
    logic          m_axis_tready_0, m_axis_tready_1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int k, cyc, n, dc;
    int acc [0:63];
    logic [DW-1:0] q0[$], q1[$];
    logic          hold0 = 1'b0, hold1 = 1'b0;
    logic [DW-1:0] hd0, hd1;

    always #5 clk = ~clk;

    in_switch #(.DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_seg_len(cfg_seg_len), .cfg_seg_num(cfg_seg_num),
        .cfg_first(cfg_first), .busy(busy), .done(done),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata_0(m_axis_tdata_0), .m_axis_tvalid_0(m_axis_tvalid_0),
        .m_axis_tready_0(m_axis_tready_0),
        .m_axis_tdata_1(m_axis_tdata_1), .m_axis_tvalid_1(m_axis_tvalid_1),
        .m_axis_tready_1(m_axis_tready_1)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records handshakes and checks that stalled data holds.
    always @(negedge clk) begin
        if (rst) begin
            hold0 = 1'b0;
            hold1 = 1'b0;
        end else begin
            if (hold0) begin
                chk("hold_v0", DW'(m_axis_tvalid_0), DW'(1));
                chk("hold_d0", m_axis_tdata_0, hd0);
            end
            if (hold1) begin
                chk("hold_v1", DW'(m_axis_tvalid_1), DW'(1));
                chk("hold_d1", m_axis_tdata_1, hd1);
            end
            if (m_axis_tvalid_0 && m_axis_tready_0) q0.push_back(m_axis_tdata_0);
            if (m_axis_tvalid_1 && m_axis_tready_1) q1.push_back(m_axis_tdata_1);
            hold0 = m_axis_tvalid_0 & ~m_axis_tready_0;
            hold1 = m_axis_tvalid_1 & ~m_axis_tready_1;
            hd0   = m_axis_tdata_0;
            hd1   = m_axis_tdata_1;
            if (done) done_cnt++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input int mode, input int c);
        case (mode)
            1:       begin m_axis_tready_0 = 1'b1; m_axis_tready_1 = !(c >= 2 && c <= 6); end
            2:       begin m_axis_tready_0 = (c % 2 == 1); m_axis_tready_1 = 1'b1; end
            default: begin m_axis_tready_0 = 1'b1; m_axis_tready_1 = 1'b1; end
        endcase
    endtask

    task automatic start(input int len, input int num, input logic first);
        cfg_start   = 1'b1;
        cfg_seg_len = LW'(len);
        cfg_seg_num = LW'(num);
        cfg_first   = first;
        next();
        cfg_start   = 1'b0;
    endtask

    task automatic stream(input int nbeats, input int mode, input int base);
        k   = 0;
        cyc = 0;
        while (k < nbeats && cyc < 100) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(base + k);
            set_rdy(mode, cyc);
            @(negedge clk);
            if (mode == 2 && cyc <= 13)
                chk("bp_tready", DW'(s_axis_tready), DW'((cyc == 0) || (cyc % 2 == 1)));
            if (s_axis_tready) begin
                acc[k] = cyc;
                k++;
            end
            next();
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        chk("stream_beats", DW'(k), DW'(nbeats));
    endtask

    // Returns at the falling edge of the cycle in which done is seen.
    task automatic wait_done(input int mode);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            set_rdy(mode, cyc);
            @(negedge clk);
            if (done) found = 1'b1;
            else begin
                next();
                cyc++;
                n++;
            end
        end
        chk("done_seen", DW'(found), DW'(1));
    endtask

    task automatic cmp_q(input string tag, input int len, input int num, input int first, input int base);
        logic [DW-1:0] e0[$], e1[$];
        for (int i = 0; i < len * num; i++) begin
            if ((((i / len) % 2) ^ first) != 0) e1.push_back(DW'(base + i));
            else                                e0.push_back(DW'(base + i));
        end
        chk({tag, "_n0"}, DW'(q0.size()), DW'(e0.size()));
        chk({tag, "_n1"}, DW'(q1.size()), DW'(e1.size()));
        for (int i = 0; i < e0.size() && i < q0.size(); i++) chk({tag, "_d0"}, q0[i], e0[i]);
        for (int i = 0; i < e1.size() && i < q1.size(); i++) chk({tag, "_d1"}, q1[i], e1[i]);
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_seg_len = '0; cfg_seg_num = '0; cfg_first = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        m_axis_tready_0 = 1'b1; m_axis_tready_1 = 1'b1;
        repeat (2) next();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",   DW'(busy), DW'(0));
        chk("rst_done",   DW'(done), DW'(0));
        chk("rst_tready", DW'(s_axis_tready), DW'(0));
        chk("rst_v0",     DW'(m_axis_tvalid_0), DW'(0));
        chk("rst_v1",     DW'(m_axis_tvalid_1), DW'(0));
        next();

        // Basic alternation: len=4 num=3 first=0
        q0.delete(); q1.delete(); dc = done_cnt;
        start(4, 3, 1'b0);
        stream(12, 0, 0);
        chk("basic_cycles", DW'(cyc), DW'(12));
        chk("basic_acc11",  DW'(acc[11]), DW'(11));
        wait_done(0);
        chk("basic_done_lat", DW'(n), DW'(1));
        chk("basic_busy_at_done", DW'(busy), DW'(0));
        next();
        @(negedge clk);
        chk("basic_done_pulse", DW'(done), DW'(0));
        chk("basic_done_cnt", DW'(done_cnt - dc), DW'(1));
        cmp_q("basic", 4, 3, 0, 0);
        next();

        // Stalled idle port: len=2 num=4 first=1, port 1 stalled while segment 1 flows to port 0
        q0.delete(); q1.delete();
        start(2, 4, 1'b1);
        stream(8, 1, 100);
        chk("stall_acc3", DW'(acc[3]), DW'(3));
        chk("stall_acc4", DW'(acc[4]), DW'(7));
        wait_done(1);
        chk("stall_done_lat", DW'(n), DW'(1));
        cmp_q("stall", 2, 4, 1, 100);
        next();

        // Backpressure on active port: len=8 num=1, ready_0 toggles
        q0.delete(); q1.delete();
        start(8, 1, 1'b0);
        stream(8, 2, 200);
        wait_done(2);
        chk("bp_done_lat", DW'(n), DW'(2));
        cmp_q("bp", 8, 1, 0, 200);
        set_rdy(0, 0);
        next();

        // Illegal starts (len=0, num=0)
        dc = done_cnt;
        start(0, 3, 1'b0);
        @(negedge clk);
        chk("ill_len_busy", DW'(busy), DW'(0));
        next();
        start(3, 0, 1'b0);
        @(negedge clk);
        chk("ill_num_busy", DW'(busy), DW'(0));
        repeat (3) next();
        @(negedge clk);
        chk("ill_no_done", DW'(done_cnt - dc), DW'(0));
        next();

        // Start while busy is ignored: len=3 num=2 keeps its config
        q0.delete(); q1.delete();
        start(3, 2, 1'b0);
        cfg_start = 1'b1; cfg_seg_len = LW'(5); cfg_seg_num = LW'(9); cfg_first = 1'b1;
        @(negedge clk);
        chk("ign_busy", DW'(busy), DW'(1));
        next();
        cfg_start = 1'b0;
        stream(6, 0, 400);
        wait_done(0);
        chk("ign_done_lat", DW'(n), DW'(1));
        cmp_q("ign", 3, 2, 0, 400);
        next();

        // Reset mid-transfer at beat 5 of len=16
        start(16, 1, 1'b0);
        stream(5, 0, 600);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_pre_v0", DW'(m_axis_tvalid_0), DW'(1));
        chk("mid_pre_d0", m_axis_tdata_0, DW'(604));
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy",   DW'(busy), DW'(0));
        chk("mid_done",   DW'(done), DW'(0));
        chk("mid_tready", DW'(s_axis_tready), DW'(0));
        chk("mid_v0",     DW'(m_axis_tvalid_0), DW'(0));
        chk("mid_v1",     DW'(m_axis_tvalid_1), DW'(0));
        chk("mid_d0",     m_axis_tdata_0, DW'(0));
        chk("mid_d1",     m_axis_tdata_1, DW'(0));
        next();
        q0.delete(); q1.delete();
        start(2, 2, 1'b0);
        stream(4, 0, 300);
        wait_done(0);
        chk("after_rst_done_lat", DW'(n), DW'(1));
        cmp_q("after_rst", 2, 2, 0, 300);

        // Back-to-back: start in the done cycle
        q0.delete(); q1.delete();
        cfg_start = 1'b1; cfg_seg_len = LW'(3); cfg_seg_num = LW'(1); cfg_first = 1'b1;
        next();
        cfg_start = 1'b0;
        @(negedge clk);
        chk("b2b_tready", DW'(s_axis_tready), DW'(1));
        chk("b2b_busy",   DW'(busy), DW'(1));
        next();
        stream(3, 0, 500);
        wait_done(0);
        chk("b2b_done_lat", DW'(n), DW'(1));
        cmp_q("b2b", 3, 1, 1, 500);
        next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/in_switch.md
# in_switch

Splits one AXI-Stream input into two AXI-Stream outputs by routing fixed-length segments alternately to port 0 and port 1. It sits at the input side of the poly-systolic data route, where it fans the DMA stream out to the two compute paths whose results are later merged back onto a single stream. A configuration pulse arms a transfer of `cfg_seg_num` segments of `cfg_seg_len` beats each. Each output has its own forward register stage, so full throughput is sustained and a stalled idle port never blocks the active one.

## Interface
- `DWIDTH`, 128, data width of all streams
- `LWIDTH`, 16, width of segment-length and segment-count fields
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `cfg_start`  in  1  one-cycle pulse that arms a transfer; honoured only while idle
- `cfg_seg_len`  in  LWIDTH  beats per segment; sampled on an accepted `cfg_start`
- `cfg_seg_num`  in  LWIDTH  segments in the transfer; sampled on an accepted `cfg_start`
- `cfg_first`  in  1  destination port of the first segment
- `busy`  out  1  high while the state is not IDLE
- `done`  out  1  one-cycle pulse when the transfer is fully drained
- `s_axis_tdata`  in  DWIDTH; `s_axis_tvalid`  in  1; `s_axis_tready`  out  1
- `m_axis_tdata_0`  out  DWIDTH; `m_axis_tvalid_0`  out  1; `m_axis_tready_0`  in  1
- `m_axis_tdata_1`  out  DWIDTH; `m_axis_tvalid_1`  out  1; `m_axis_tready_1`  in  1

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - `s_axis_tready` = 0.
  - `cfg_start` with `cfg_seg_len` != 0 and `cfg_seg_num` != 0: latch both values, set dest = `cfg_first`, clear `beat_cnt` and `seg_cnt`, go to RUN.
  - `cfg_start` with either value 0: ignored; stay in IDLE; no `done`.
- **RUN**
  - `s_axis_tready` = `~m_axis_tvalid_d | m_axis_tready_d`, where d = current dest.
  - Accept = `s_axis_tvalid & s_axis_tready`. An accepted beat loads output register d and sets `m_axis_tvalid_d`.
  - On accept, when `beat_cnt` == len-1: clear `beat_cnt`, toggle dest, increment `seg_cnt`. Otherwise increment `beat_cnt`.
  - Accept of beat len-1 in segment num-1: go to DRAIN.
- **DRAIN**
  - `s_axis_tready` = 0.
  - When `m_axis_tvalid_0` = 0 and `m_axis_tvalid_1` = 0: go to IDLE and register `done` = 1.
- **Output register, per port p**
  - `m_axis_tvalid_p` clears on `m_axis_tready_p` unless a new load happens in the same cycle. Load wins.
  - Data is held stable while `m_axis_tvalid_p & ~m_axis_tready_p`.
  - The register of the non-current port keeps draining independently.
- `cfg_start` while `busy` is ignored and leaves the latched config untouched.
- `cfg_*` inputs are don't-care except in the cycle of an accepted start.
- Counters are LWIDTH bits. `cfg_seg_len` = 2^LWIDTH-1 is legal; the counter cannot wrap before the terminal compare.

## Timing
- **Reset** (takes effect in the cycle `rst` is high, including mid-transfer):
  - state IDLE
  - `busy` = 0, `done` = 0, `s_axis_tready` = 0
  - `m_axis_tvalid_0/1` = 0, `m_axis_tdata_0/1` = 0
  - all counters 0
  - In-flight data is discarded.
- **Latency**:
  - Input accept at cycle n gives `m_axis_tvalid_d` = 1 with that data at cycle n+1.
  - Start accepted at cycle n gives `s_axis_tready` = 1 at n+1 (if dest register empty).
- **Throughput**: one beat per cycle while the current dest sink holds `tready` = 1, including across segment boundaries.
- **`busy`**: combinational from state. `done` is high in the first IDLE cycle, in which `busy` = 0.
- **Back-to-back transfers**: a `cfg_start` in the same cycle as `done` is accepted.
- **Last-beat timing**: if the final output handshake is at cycle m, `done` = 1 at cycle m+1.
- **Simultaneous unload and load on the same port**: the new beat is registered and `tvalid` stays 1.

## Test plan
- **Basic alternation**: len=4, num=3, first=0, source always valid, sinks always ready, data 0..11.
  - Port 0 receives 0–3 and 8–11; port 1 receives 4–7.
  - `s_axis_tready` holds 1 for 12 consecutive cycles.
  - `done` pulses exactly once, 1 cycle after beat 11 leaves.
- **Stalled idle port**: len=2, num=4, first=1; `m_axis_tready_1` low during segment 2.
  - Input keeps flowing into port 0 until port 1 is needed again.
  - Held `m_axis_tdata_1` stays stable; no beats lost or duplicated.
- **Backpressure on active port**: len=8, num=1; `m_axis_tready_0` toggles every cycle.
  - `s_axis_tready` follows the register-empty/ready rule.
  - Port 0 outputs 8 beats in order; port 1 stays silent.
- **Illegal and ignored starts**:
  - start with len=0: no `busy`, no `done`.
  - start while busy with len=5: original len=3 transfer completes with len=3.
- **Reset mid-transfer**: `rst` high while `m_axis_tvalid_0` = 1 at beat 5 of len=16.
  - Next cycle all outputs are 0 and state is IDLE.
  - A new len=2, num=2 transfer then runs cleanly.
- **Back-to-back**: `cfg_start` in the `done` cycle.
  - Second transfer begins with `s_axis_tready` = 1 the following cycle.
